// File: rtl/weight_loader.sv
// Loads one ROWS x COLS weight tile from a valid/ready stream, shifts it down the
// PE columns bottom row first, then issues staggered per-row switch pulses on go.
module weight_loader #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [COLS*DATA_WIDTH-1:0] in_data,
    input  logic                       sw_go,
    output logic [COLS*DATA_WIDTH-1:0] col_weight_out,
    output logic [COLS-1:0]            col_accept_out,
    output logic [ROWS-1:0]            row_switch_out,
    output logic                       busy,
    output logic                       tile_done
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW = COLS * DATA_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ARMED,
        S_SWITCH
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_k;
    logic [BW-1:0]   r_buf [ROWS];

    logic            r_in_ready;
    logic [BW-1:0]   r_weight;
    logic [COLS-1:0] r_accept;
    logic [ROWS-1:0] r_switch;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_k_nxt;
    logic [BW-1:0]   w_buf_nxt [ROWS];
    logic            w_ready_nxt;
    logic [BW-1:0]   w_weight_nxt;
    logic [COLS-1:0] w_accept_nxt;
    logic [ROWS-1:0] w_switch_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    // Outputs are registered from the next-state view, so the first LOAD cycle
    // can forward the final beat through the buffer on the same edge it is written.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_buf_nxt   = r_buf;

        unique case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_buf_nxt[r_cnt] = in_data;
                    if (r_cnt == LAST) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                        w_k_nxt     = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (r_k == LAST) begin
                    w_state_nxt = S_ARMED;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            S_ARMED: begin
                if (sw_go) begin
                    w_state_nxt = S_SWITCH;
                    w_k_nxt     = '0;
                end
            end
            S_SWITCH: begin
                if (r_k == LAST) begin
                    w_state_nxt = S_IDLE;
                    w_k_nxt     = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt  = (w_state_nxt == S_IDLE);
        w_accept_nxt = '0;
        w_weight_nxt = '0;
        w_switch_nxt = '0;
        w_done_nxt   = 1'b0;
        if (w_state_nxt == S_LOAD) begin
            w_accept_nxt = '1;
            w_weight_nxt = w_buf_nxt[LAST - w_k_nxt];
        end
        if (w_state_nxt == S_SWITCH) begin
            w_switch_nxt = ROWS'(1) << w_k_nxt;
            w_done_nxt   = (w_k_nxt == LAST);
        end
        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_cnt_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_weight   <= '0;
            r_accept   <= '0;
            r_switch   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_k        <= w_k_nxt;
            r_buf      <= w_buf_nxt;
            r_in_ready <= w_ready_nxt;
            r_weight   <= w_weight_nxt;
            r_accept   <= w_accept_nxt;
            r_switch   <= w_switch_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign in_ready       = r_in_ready;
    assign col_weight_out = r_weight;
    assign col_accept_out = r_accept;
    assign row_switch_out = r_switch;
    assign busy           = r_busy;
    assign tile_done      = r_done;

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Drives the north and west control edges of the PE systolic array: each column's weight input and weight-accept, and each row's switch input.
- Collects one weight tile of ROWS×COLS values from an upstream valid/ready stream into a local buffer.
- Shifts the tile down the columns in reverse row order, so that PE row r holds tile row r in its background weight register.
- On a go request from the compute sequencer, issues one-cycle switch pulses to the rows, staggered by one cycle per row.

Parameters:
- ROWS, 2, number of PE rows; also the number of input beats per tile.
- COLS, 2, number of PE columns; also the number of weights per beat.
- DATA_WIDTH, 16, width of one signed fixed-point weight.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  COLS*DATA_WIDTH  one tile row; column c is in bits [c*DATA_WIDTH +: DATA_WIDTH].
- sw_go  in  1  request to activate the loaded tile.
- col_weight_out  out  COLS*DATA_WIDTH  per-column weight into the PE row-0 weight input; same packing as in_data.
- col_accept_out  out  COLS  per-column weight-accept into every PE of that column.
- row_switch_out  out  ROWS  per-row switch into the column-0 PE of that row.
- busy  out  1  high whenever the FSM is not in IDLE, or the buffer holds at least one beat.
- tile_done  out  1  one-cycle pulse marking the final switch pulse.

Behaviour:
- All outputs are registered. On any clk edge with rst=1:
  - all outputs go to 0, including in_ready;
  - the beat counter and buffer contents are discarded and the FSM enters IDLE.
- Reset mid-operation aborts the tile with no further accept or switch pulses; a partially shifted tile is not recovered.
- The first cycle after rst deasserts is IDLE with in_ready=1.
- FSM states and transitions:
  - IDLE → LOAD when the ROWS-th beat is accepted.
  - LOAD → ARMED after exactly ROWS cycles.
  - ARMED → SWITCH when sw_go=1 is sampled.
  - SWITCH → IDLE after ROWS cycles.
- IDLE:
  - in_ready=1.
  - A beat transfers on a clk edge with in_valid=1 and in_ready=1. It is stored in buf[cnt], and cnt increments from 0 to ROWS-1.
  - in_valid=0 holds cnt unchanged; gaps between beats are allowed.
  - On the edge that accepts beat ROWS-1: in_ready drops to 0 and the next cycle is LOAD.
  - The buffer is then full and no further beat can transfer until IDLE is re-entered.
- LOAD:
  - Lasts exactly ROWS cycles, k=0..ROWS-1.
  - col_accept_out is all ones and col_weight_out = buf[ROWS-1-k]. The bottom row is emitted first.
  - Values pass through bit-exact; no arithmetic or resizing.
  - The first LOAD cycle immediately follows the final input handshake edge.
- ARMED:
  - col_accept_out=0, col_weight_out=0, row_switch_out=0.
  - sw_go is sampled every cycle starting with the first ARMED cycle; the FSM waits indefinitely.
  - sw_go is ignored in all other states; it is not latched.
- SWITCH:
  - If sw_go=1 in ARMED cycle G, row_switch_out[r] is high only in cycle G+1+r, for r=0..ROWS-1. Exactly one bit is high per cycle.
  - tile_done=1 in the same cycle as the row_switch_out[ROWS-1] pulse.
  - The cycle after that is IDLE with in_ready=1.
  - Loading the next tile overlaps with array computation, because the PE background registers are free after the switch.
- Outside LOAD, col_accept_out=0 and col_weight_out=0. Outside SWITCH, row_switch_out=0.
- ROWS=1 is legal: one-cycle LOAD and a single switch pulse coinciding with tile_done.

Test Plan:
- Reset: assert rst for 2 cycles mid-LOAD (ROWS=2, COLS=2) → all outputs 0 during reset; in_ready=1 the cycle after release; no accept or switch pulses follow.
- Basic tile: beats {0x0100,0x0200} then {0x0300,0x0400}, back to back → accept=2'b11 for 2 cycles starting the cycle after the 2nd handshake, carrying {0x0300,0x0400} then {0x0100,0x0200}. A 2-deep shift model of the PE columns ends with row0 = {0x0100,0x0200} and row1 = {0x0300,0x0400}.
- Gapped input: in_valid toggled 1,0,0,1 → only 2 beats stored; LOAD starts the cycle after the 4th cycle's edge; emitted data as in the basic tile.
- Switch timing: sw_go held 0 for 5 ARMED cycles, then 1 in cycle G → row_switch_out = 2'b01 at G+1 and 2'b10 at G+2; tile_done at G+2; in_ready=1 at G+3.
- Ignored sw_go and backpressure: sw_go=1 throughout IDLE and LOAD → no switch pulse until the first ARMED cycle. in_valid held 1 during LOAD, ARMED and SWITCH → no extra beats consumed (in_ready=0).
- Negative values: beats {0xFF00,0x8000},{0x7FFF,0x0001} → emitted bit-exact in reverse row order; second tile accepted right after tile_done.
